// File: rtl/mem_port_serializer.sv
// Serialises the scratchpad-port requests of a clock-enabled HLS kernel onto a
// single host read/write memory channel, lowest port first, one kernel cycle at a time.
module mem_port_serializer #(
    parameter int NPORTS     = 2,
    parameter int ADDR_WID   = 14,
    parameter int DATA_WID   = 32,
    parameter int BYTE_SHIFT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [63:0]                  read_base,
    input  logic [63:0]                  write_base,
    input  logic [63:0]                  read_size_input,
    input  logic [63:0]                  read_ready,
    input  logic [DATA_WID-1:0]          read_data,
    input  logic [63:0]                  write_ready,
    output logic                         read_enable,
    output logic [63:0]                  read_addr,
    output logic [63:0]                  read_size_output,
    output logic                         write_enable,
    output logic [63:0]                  write_addr,
    output logic [63:0]                  write_size,
    output logic [DATA_WID-1:0]          write_data,
    output logic                         done,
    output logic                         k_start,
    output logic                         k_en,
    input  logic [NPORTS-1:0]            k_ce,
    input  logic [NPORTS-1:0]            k_we,
    input  logic [NPORTS*ADDR_WID-1:0]   k_addr,
    input  logic [NPORTS*DATA_WID-1:0]   k_d,
    output logic [NPORTS*DATA_WID-1:0]   k_q,
    input  logic                         k_done,
    output logic [31:0]                  access_count,
    output logic [31:0]                  step_count
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic [2:0] {
        STEP, CAPTURE, SCAN, ISSUE, WAIT, FINISH, HALT
    } state_t;

    state_t                      state;
    logic [NPORTS-1:0]           pending;
    logic                        done_seen;
    logic [PW-1:0]               sel;
    logic [PW-1:0]               low_idx;
    logic [NPORTS-1:0]           we_lat;
    logic [NPORTS*ADDR_WID-1:0]  addr_lat;
    logic [NPORTS*DATA_WID-1:0]  d_lat;

    logic                        sel_we;
    logic [ADDR_WID-1:0]         sel_addr;
    logic [DATA_WID-1:0]         sel_d;
    logic [63:0]                 byte_off;

    // NOTE: the default before the loop keeps this block purely combinational; no latch.
    always_comb begin
        low_idx = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (pending[i]) low_idx = PW'(i);
        end
    end

    assign sel_we   = we_lat[sel];
    assign sel_addr = addr_lat[int'(sel)*ADDR_WID +: ADDR_WID];
    assign sel_d    = d_lat[int'(sel)*DATA_WID +: DATA_WID];
    assign byte_off = 64'(sel_addr) << BYTE_SHIFT;

    // NOTE: the request snapshot has no reset; it is always rewritten in CAPTURE before use.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            we_lat   <= k_we;
            addr_lat <= k_addr;
            d_lat    <= k_d;
        end
    end

    // k_en is raised by STEP, so the kernel advances on the same edge CAPTURE samples
    // its requests; k_q is then refreshed before the next k_en cycle.
    // NOTE: every register here uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= STEP;
            pending          <= '0;
            done_seen        <= 1'b0;
            sel              <= '0;
            read_enable      <= 1'b0;
            read_addr        <= '0;
            read_size_output <= '0;
            write_enable     <= 1'b0;
            write_addr       <= '0;
            write_size       <= '0;
            write_data       <= '0;
            done             <= 1'b0;
            k_start          <= 1'b1;
            k_en             <= 1'b0;
            k_q              <= '0;
            access_count     <= '0;
            step_count       <= '0;
        end else begin
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            done         <= 1'b0;
            k_en         <= 1'b0;
            case (state)
                STEP: begin
                    k_en       <= 1'b1;
                    step_count <= step_count + 32'd1;
                    state      <= CAPTURE;
                end
                CAPTURE: begin
                    pending   <= k_ce;
                    done_seen <= k_done;
                    state     <= SCAN;
                end
                SCAN: begin
                    if (|pending) begin
                        sel   <= low_idx;
                        state <= ISSUE;
                    end else if (done_seen) begin
                        state <= FINISH;
                    end else begin
                        state <= STEP;
                    end
                end
                ISSUE: begin
                    if (sel_we) begin
                        write_enable <= 1'b1;
                        write_addr   <= write_base + byte_off;
                        write_data   <= sel_d;
                        write_size   <= read_size_input;
                    end else begin
                        read_enable      <= 1'b1;
                        read_addr        <= read_base + byte_off;
                        read_size_output <= read_size_input;
                    end
                    access_count <= access_count + 32'd1;
                    state        <= WAIT;
                end
                WAIT: begin
                    if (!sel_we && read_ready == 64'd1) begin
                        k_q[int'(sel)*DATA_WID +: DATA_WID] <= read_data;
                        pending[sel] <= 1'b0;
                        state        <= SCAN;
                    end else if (sel_we && write_ready == 64'd1) begin
                        pending[sel] <= 1'b0;
                        state        <= SCAN;
                    end
                end
                FINISH: begin
                    done    <= 1'b1;
                    k_start <= 1'b0;
                    state   <= HALT;
                end
                HALT:    state <= HALT;
                default: state <= STEP;
            endcase
        end
    end

endmodule
